// File: rtl/bit_stuffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stuffer_pkg
//  Description : Shared constants and types for the SIE transmit bit stuffer.
//                USB_STUFF_RUN  - consecutive 1s that force a stuffed 0
//                stuff_state_e  - bit stuffer FSM state encoding
//  Revision    : 1.0  initial release
// ============================================================================
package bit_stuffer_pkg;

    localparam int USB_STUFF_RUN = 6;

    typedef enum logic [0:0] {
        ST_PASS  = 1'b0,
        ST_STUFF = 1'b1
    } stuff_state_e;

endpackage : bit_stuffer_pkg
`default_nettype wire

// File: rtl/bit_stuffer_stuff_run_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stuff_run_counter
//  Description : Counts consecutive emitted data 1s and flags when the next
//                data 1 completes a run of RUN_LEN.
//  Ports       : clk  in  system clock
//                rst  in  asynchronous active-low reset
//                clr  in  clear the run count (has priority over inc)
//                inc  in  count one more data 1
//                hit  out run count equals RUN_LEN-1
//  Revision    : 1.0  initial release
// ============================================================================
module stuff_run_counter #(
    parameter int RUN_LEN = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int CNT_W = $clog2(RUN_LEN);

    logic [CNT_W-1:0] ones_cnt_q;
    logic [CNT_W-1:0] ones_cnt_d;

    always_comb begin
        ones_cnt_d = ones_cnt_q;
        if (clr) begin
            ones_cnt_d = '0;
        end else if (inc) begin
            ones_cnt_d = ones_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_cnt_q <= '0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
        end
    end

    assign hit = (ones_cnt_q == CNT_W'(RUN_LEN - 1));

endmodule : stuff_run_counter
`default_nettype wire

// File: rtl/bit_stuffer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stuffer
//  Description : Serial bit stuffer for the SIE transmit path. Inserts a 0
//                after every RUN_LEN consecutive 1s and stalls upstream while
//                the stuffed bit is emitted. One-entry output register with
//                valid/ready handshake on both sides.
//  Ports       : clk        in   system clock
//                rst        in   asynchronous active-low reset
//                in_bit     in   serial bit from mux stage
//                in_valid   in   in_bit valid
//                in_last    in   in_bit is last bit of packet
//                in_ready   out  block accepts in_bit this cycle
//                out_bit    out  stuffed serial bit to NRZI encoder
//                out_valid  out  out_bit valid
//                out_last   out  out_bit is final bit of stuffed packet
//                out_ready  in   NRZI encoder accepts out_bit
//                stuff_cnt  out  stuffed bits in current/most recent packet
//                pkt_done   out  pulse when the out_last bit transfers
//  Revision    : 1.0  initial release
// ============================================================================
module bit_stuffer
    import bit_stuffer_pkg::*;
#(
    parameter int RUN_LEN = USB_STUFF_RUN,
    parameter int STAT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bit,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [STAT_W-1:0] stuff_cnt,
    output logic              pkt_done
);

    stuff_state_e      state_q,        state_d;
    logic              out_bit_q,      out_bit_d;
    logic              out_valid_q,    out_valid_d;
    logic              out_last_q,     out_last_d;
    logic              pending_last_q, pending_last_d;
    logic              first_q,        first_d;
    logic [STAT_W-1:0] stuff_cnt_q,    stuff_cnt_d;

    logic load_ok;
    logic in_xfer;
    logic run_clr;
    logic run_inc;
    logic run_hit;

    // Output register can take a new bit when empty or being drained.
    assign load_ok  = !out_valid_q || out_ready;
    // Gated by rst so upstream sees no acceptance while reset is held.
    assign in_ready = rst && (state_q == ST_PASS) && load_ok;
    assign in_xfer  = in_valid && in_ready;

    stuff_run_counter #(
        .RUN_LEN (RUN_LEN)
    ) u_run_counter (
        .clk (clk),
        .rst (rst),
        .clr (run_clr),
        .inc (run_inc),
        .hit (run_hit)
    );

    always_comb begin
        state_d        = state_q;
        out_bit_d      = out_bit_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        pending_last_d = pending_last_q;
        first_d        = first_q;
        stuff_cnt_d    = stuff_cnt_q;
        run_clr        = 1'b0;
        run_inc        = 1'b0;

        case (state_q)
            ST_PASS: begin
                if (in_xfer) begin
                    out_bit_d   = in_bit;
                    out_valid_d = 1'b1;
                    out_last_d  = in_last;

                    if (first_q) begin
                        stuff_cnt_d = '0;
                        first_d     = 1'b0;
                    end

                    if (in_bit && run_hit) begin
                        // Data bit completes the run: the stuffed 0 that
                        // follows inherits the packet-end marker instead.
                        run_clr        = 1'b1;
                        state_d        = ST_STUFF;
                        pending_last_d = in_last;
                        out_last_d     = 1'b0;
                    end else if (in_bit) begin
                        run_inc = 1'b1;
                    end else begin
                        run_clr = 1'b1;
                    end

                    if (in_last) begin
                        run_clr = 1'b1;
                        first_d = 1'b1;
                    end
                end else if (load_ok) begin
                    out_valid_d = 1'b0;
                end
            end

            ST_STUFF: begin
                if (load_ok) begin
                    out_bit_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_last_d  = pending_last_q;
                    if (stuff_cnt_q != '1) begin
                        stuff_cnt_d = stuff_cnt_q + 1'b1;
                    end
                    state_d = ST_PASS;
                end
            end

            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_PASS;
            out_bit_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            pending_last_q <= 1'b0;
            first_q        <= 1'b1;
            stuff_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            out_bit_q      <= out_bit_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            pending_last_q <= pending_last_d;
            first_q        <= first_d;
            stuff_cnt_q    <= stuff_cnt_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign stuff_cnt = stuff_cnt_q;
    // Asserted in the very cycle the final bit is handed over.
    assign pkt_done  = out_valid_q && out_ready && out_last_q;

endmodule : bit_stuffer
`default_nettype wire

// File: tb/tb_bit_stuffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_stuffer
//  Description : Self-checking bench for bit_stuffer. Expected output stream
//                is queued when a packet is driven and popped as the DUT
//                transfers bits.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bit_stuffer;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_bit;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic [7:0] stuff_cnt;
    logic       pkt_done;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   pkt_cnt  = 0;
    exp_t exp_q[$];

    bit_stuffer #(
        .RUN_LEN (6),
        .STAT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .stuff_cnt (stuff_cnt),
        .pkt_done  (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every output transfer is matched against the queue.
    always @(negedge clk) begin
        if (pkt_done === 1'b1) pkt_cnt++;
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_bit",  32'(out_bit),  32'(e.b));
                check("out_last", 32'(out_last), 32'(e.last));
                check("pkt_done", 32'(pkt_done), 32'(e.last));
            end
        end
    end

    // Drive one packet (bits LSB first). Expected stuffed stream is queued
    // up front; the cycle after any stuff-triggering bit must show in_ready=0.
    task automatic send(input logic [31:0] bits, input int n, input bit with_last,
                        input bit stall_after_stuff);
        logic [31:0] stuff_at;
        int   ones;
        int   i;
        int   guard;
        bit   prev_stuff;
        bit   accepted;
        exp_t e;
        ones = 0;
        stuff_at = '0;
        for (int k = 0; k < n; k++) begin
            bit lst;
            lst = with_last && (k == n - 1);
            if (bits[k]) begin
                ones++;
                if (ones == 6) begin
                    stuff_at[k] = 1'b1;
                    e.b = 1'b1; e.last = 1'b0; exp_q.push_back(e);
                    e.b = 1'b0; e.last = lst;  exp_q.push_back(e);
                    ones = 0;
                end else begin
                    e.b = 1'b1; e.last = lst; exp_q.push_back(e);
                end
            end else begin
                ones = 0;
                e.b = 1'b0; e.last = lst; exp_q.push_back(e);
            end
        end

        i = 0;
        guard = 0;
        prev_stuff = 1'b0;
        while (i < n) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            in_last  = with_last && (i == n - 1);
            @(negedge clk);
            if (prev_stuff) begin
                check("stuff_stall_in_ready", 32'(in_ready), 32'd0);
                accepted = 1'b0;
                @(posedge clk); #1;
                if (stall_after_stuff) begin
                    out_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        check("hold_out_valid", 32'(out_valid), 32'd1);
                        check("hold_out_bit",   32'(out_bit),   32'd0);
                        check("hold_in_ready",  32'(in_ready),  32'd0);
                        @(posedge clk); #1;
                    end
                    out_ready = 1'b1;
                end
                prev_stuff = 1'b0;
            end else begin
                accepted = (in_ready === 1'b1);
                @(posedge clk); #1;
                if (accepted) begin
                    prev_stuff = stuff_at[i];
                    i++;
                end
            end
            guard++;
            if (guard > 200) begin
                check("send_timeout", 32'(i), 32'(n));
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (prev_stuff) begin
            @(negedge clk);
            check("stuff_stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_bit"},   32'(out_bit),   32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_stuff_cnt"}, 32'(stuff_cnt), 32'd0);
        check({tag, "_pkt_done"},  32'(pkt_done),  32'd0);
    endtask

    initial begin
        int p0;
        rst       = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: 8 ones -> 1111110 11
        p0 = pkt_cnt;
        send(32'h0000_00FF, 8, 1'b1, 1'b0);
        drain();
        check("t1_stuff_cnt", 32'(stuff_cnt), 32'd1);
        check("t1_pkt_done_pulses", 32'(pkt_cnt - p0), 32'd1);

        // 2: 6 ones -> 1111110, last on stuffed 0
        p0 = pkt_cnt;
        send(32'h0000_003F, 6, 1'b1, 1'b0);
        drain();
        check("t2_stuff_cnt", 32'(stuff_cnt), 32'd1);
        check("t2_pkt_done_pulses", 32'(pkt_cnt - p0), 32'd1);

        // 3: alternating pattern passes unchanged
        p0 = pkt_cnt;
        send(32'h0000_5555, 16, 1'b1, 1'b0);
        drain();
        check("t3_stuff_cnt", 32'(stuff_cnt), 32'd0);
        check("t3_pkt_done_pulses", 32'(pkt_cnt - p0), 32'd1);

        // 4: 13 ones -> two stuffs; next packet start clears counter
        send(32'h0000_1FFF, 13, 1'b1, 1'b0);
        drain();
        check("t4_stuff_cnt", 32'(stuff_cnt), 32'd2);
        send(32'h0000_0000, 1, 1'b1, 1'b0);
        drain();
        check("t4_next_pkt_stuff_cnt", 32'(stuff_cnt), 32'd0);

        // 5: back-pressure while the stuffed 0 is held
        p0 = pkt_cnt;
        send(32'h0000_00FF, 8, 1'b1, 1'b1);
        drain();
        check("t5_stuff_cnt", 32'(stuff_cnt), 32'd1);
        check("t5_pkt_done_pulses", 32'(pkt_cnt - p0), 32'd1);

        // 6: reset mid-packet, then a fresh short packet
        p0 = pkt_cnt;
        send(32'h0000_000F, 4, 1'b0, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b1;
        send(32'h0000_0007, 3, 1'b1, 1'b0);
        drain();
        check("t6_stuff_cnt", 32'(stuff_cnt), 32'd0);
        check("t6_pkt_done_pulses", 32'(pkt_cnt - p0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_bit_stuffer
`default_nettype wire
